post_hash_reorder_buffer: RTL
=============================

// Module: post_hash_reorder_buffer
// PURPOSE
// - Parametrised successor of the post-hash row merge/reorder/sync path: collects per-PE hash results that arrive
//   out of order and re-emits them as complete, in-order ISSUE_W-wide windows to the match stage.
// - Sits between the hash PE array and the match-PE dispatcher. Holds up to DEPTH windows in flight.
// - Adds runtime occupancy cap, out-of-range and duplicate-result detection, and per-window delim passthrough.
// PARAMETERS
// - NUM_PE      4   result lanes accepted per cycle
// - ISSUE_W     16  positions per window (power of 2)
// - DEPTH       8   window slots (power of 2, >=2)
// - ADDR_W      32  byte-address width
// - META_W      4   meta match length width
// PORTS
// - clk                 in   1                 clock
// - rst                 in   1                 reset: one clock; reset is synchronous and active-high
// - cfg_max_windows     in   log2(DEPTH)+1     occupancy cap, 1..DEPTH; 0 treated as 1
// - alloc_valid         in   1                 issue side opens a window
// - alloc_head_addr     in   ADDR_W            window base, ISSUE_W-aligned
// - alloc_data          in   ISSUE_W*8         window bytes
// - alloc_delim         in   1                 window ends a block
// - alloc_ready         out  1                 slot free and occupancy < cap
// - res_valid           in   NUM_PE            per-lane result strobe (no backpressure)
// - res_addr            in   NUM_PE*ADDR_W     position of result
// - res_hist_valid      in   NUM_PE            history hit
// - res_hist_addr       in   NUM_PE*ADDR_W     history address
// - res_meta_len        in   NUM_PE*META_W     meta match length
// - res_can_ext         in   NUM_PE            meta match extendable
// - out_valid           out  1                 complete window available
// - out_head_addr       out  ADDR_W            window base
// - out_hist_valid      out  ISSUE_W
// - out_hist_addr       out  ISSUE_W*ADDR_W
// - out_meta_len        out  ISSUE_W*META_W
// - out_can_ext         out  ISSUE_W
// - out_data            out  ISSUE_W*8
// - out_delim           out  1
// - out_ready           in   1
// - occupancy           out  log2(DEPTH)+1     windows allocated, not yet retired
// - err_sticky          out  2                 [0] result to unallocated window, [1] duplicate position
// BEHAVIOUR
// - Reset: all slot fill bitmaps 0, head/tail ptr 0, occupancy 0, out_valid 0, out_* data 0, err_sticky 0,
//   alloc_ready 0 during reset. In-flight results and windows are discarded; no partial output.
// - Alloc: handshake on alloc_valid&alloc_ready writes slot[tail], clears its fill bitmap, tail++ (mod DEPTH).
//   alloc_ready = ~rst & (occupancy < max(cfg_max_windows,1)) & (occupancy < DEPTH); registered inputs only,
//   no combinational path from out_ready. Unaligned head_addr: low bits ignored.
// - Result: slot = (res_addr/ISSUE_W) mod DEPTH, off = res_addr mod ISSUE_W. Accepted only if slot is
//   allocated and slot head_addr matches res_addr upper bits; else dropped and err_sticky[0] set.
//   Writes fields at off, sets fill[off]. Bit already set, or two lanes same position same cycle: keep
//   lowest-lane value, set err_sticky[1]. Results to a slot allocated in the same cycle are legal.
// - Retire: when fill[head]==all-ones and (out_valid==0 or out_ready), slot[head] loads output register,
//   head++, slot freed. Latency: final result at cycle t -> out_valid at t+1. One window per cycle max.
// - Output: out_* held stable while out_valid&~out_ready. Back-to-back complete windows stream at 1/cycle.
// - Occupancy: +1 on alloc, -1 on retire, unchanged on both same cycle. Slot freed on retire may be
//   re-allocated next cycle (not same cycle). Wrap-around of head/tail via extra ptr bit for full/empty.
// - out_delim copies alloc_delim of that window; no flush, ordering unaffected.
// - cfg_max_windows change mid-run: new cap applies next cycle; never evicts existing windows.
// STRUCTURE
// - Shared header parameters.vh: ISSUE_W, ADDR_W, META_W defaults, err bit indices.
// - Sub-module rob_slot_bank: DEPTH x ISSUE_W result storage + fill bitmaps with NUM_PE write ports;
//   top holds pointers, occupancy, alloc/retire control and output register.
// TESTING
// - In-order: alloc base 0, 16 results lanes 0-3 over 4 cycles -> out_valid cycle after last, head 0, all fields match.
// - Reverse order: alloc 0,16,32; fill window 32 then 16 then 0 -> outputs 0,16,32 in order, none early.
// - Cap: cfg_max_windows=2, three allocs back-to-back -> alloc_ready low after 2nd until first retire.
// - Backpressure: out_ready=0 for 5 cycles with 3 complete windows -> out_* stable, then 3 windows on 3 cycles.
// - Errors: result addr 64 with no window 64 -> err_sticky=01; two lanes both addr 5 -> err_sticky[1]=1, lane0 value kept.
// - Reset mid-run: rst at cycle with 2 partial windows -> occupancy 0, out_valid 0 next cycle, fresh alloc works.

Source files
------------

// File: rtl/post_hash_reorder_buffer_pkg.sv
// Shared constants for the post-hash reorder buffer.
// Holds the default geometry, which the interface and top use as parameter
// defaults, and the bit positions inside err_sticky.
package post_hash_reorder_buffer_pkg;
  localparam int NUM_PE_DEF  = 4;   // result lanes per cycle
  localparam int ISSUE_W_DEF = 16;  // positions per window
  localparam int DEPTH_DEF   = 8;   // window slots
  localparam int ADDR_W_DEF  = 32;  // byte-address width
  localparam int META_W_DEF  = 4;   // meta match length width

  localparam int ERR_W   = 2;
  localparam int ERR_OOR = 0;  // result aimed at a window that is not allocated
  localparam int ERR_DUP = 1;  // position written twice
endpackage

// File: rtl/post_hash_reorder_buffer_if.sv
// Bundle of the alloc, result, output and status signals of the reorder buffer.
// The slave modport is the buffer itself. The master modport is its environment:
// the issue side, the hash PE array and the match dispatcher.
interface post_hash_reorder_buffer_if
  import post_hash_reorder_buffer_pkg::*;
#(
  parameter int NUM_PE  = NUM_PE_DEF,
  parameter int ISSUE_W = ISSUE_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int META_W  = META_W_DEF
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]                    cfg_max_windows;
  logic                                alloc_valid;
  logic [ADDR_W-1:0]                   alloc_head_addr;
  logic [ISSUE_W-1:0][7:0]             alloc_data;
  logic                                alloc_delim;
  logic                                alloc_ready;
  logic [NUM_PE-1:0]                   res_valid;
  logic [NUM_PE-1:0][ADDR_W-1:0]       res_addr;
  logic [NUM_PE-1:0]                   res_hist_valid;
  logic [NUM_PE-1:0][ADDR_W-1:0]       res_hist_addr;
  logic [NUM_PE-1:0][META_W-1:0]       res_meta_len;
  logic [NUM_PE-1:0]                   res_can_ext;
  logic                                out_valid;
  logic [ADDR_W-1:0]                   out_head_addr;
  logic [ISSUE_W-1:0]                  out_hist_valid;
  logic [ISSUE_W-1:0][ADDR_W-1:0]      out_hist_addr;
  logic [ISSUE_W-1:0][META_W-1:0]      out_meta_len;
  logic [ISSUE_W-1:0]                  out_can_ext;
  logic [ISSUE_W-1:0][7:0]             out_data;
  logic                                out_delim;
  logic                                out_ready;
  logic [PTR_W-1:0]                    occupancy;
  logic [ERR_W-1:0]                    err_sticky;

  modport slave (
    input  cfg_max_windows, alloc_valid, alloc_head_addr, alloc_data, alloc_delim,
           res_valid, res_addr, res_hist_valid, res_hist_addr, res_meta_len, res_can_ext,
           out_ready,
    output alloc_ready, out_valid, out_head_addr, out_hist_valid, out_hist_addr,
           out_meta_len, out_can_ext, out_data, out_delim, occupancy, err_sticky
  );

  modport master (
    output cfg_max_windows, alloc_valid, alloc_head_addr, alloc_data, alloc_delim,
           res_valid, res_addr, res_hist_valid, res_hist_addr, res_meta_len, res_can_ext,
           out_ready,
    input  alloc_ready, out_valid, out_head_addr, out_hist_valid, out_hist_addr,
           out_meta_len, out_can_ext, out_data, out_delim, occupancy, err_sticky
  );
endinterface

// File: rtl/post_hash_reorder_buffer_rob_slot_bank.sv
// Per-position result storage and fill bitmaps for DEPTH windows, with
// NUM_PE write ports.
// Ports:
//   clk, rst          clock; synchronous active-high reset (clears the fill bitmaps)
//   clr_en/clr_slot   clears the fill bitmap of a newly allocated slot
//   we/wslot/woff     per-lane write of an already-accepted result
//   w_*               per-lane result fields
//   rd_slot           slot read out; rd_* show next-state contents, this cycle's writes included
//   dup               a lane hit a position that was already filled
module rob_slot_bank #(
  parameter int NUM_PE  = 4,
  parameter int ISSUE_W = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 32,
  parameter int META_W  = 4,
  localparam int OFF_W  = $clog2(ISSUE_W),
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_en,
  input  logic [IDX_W-1:0]                clr_slot,
  input  logic [NUM_PE-1:0]               we,
  input  logic [NUM_PE-1:0][IDX_W-1:0]    wslot,
  input  logic [NUM_PE-1:0][OFF_W-1:0]    woff,
  input  logic [NUM_PE-1:0]               w_hist_valid,
  input  logic [NUM_PE-1:0][ADDR_W-1:0]   w_hist_addr,
  input  logic [NUM_PE-1:0][META_W-1:0]   w_meta_len,
  input  logic [NUM_PE-1:0]               w_can_ext,
  input  logic [IDX_W-1:0]                rd_slot,
  output logic                            rd_full,
  output logic [ISSUE_W-1:0]              rd_hist_valid,
  output logic [ISSUE_W-1:0][ADDR_W-1:0]  rd_hist_addr,
  output logic [ISSUE_W-1:0][META_W-1:0]  rd_meta_len,
  output logic [ISSUE_W-1:0]              rd_can_ext,
  output logic                            dup
);
  logic [DEPTH-1:0][ISSUE_W-1:0]              fill_q, fill_d;
  logic [DEPTH-1:0][ISSUE_W-1:0]              hv_q, hv_d;
  logic [DEPTH-1:0][ISSUE_W-1:0][ADDR_W-1:0]  ha_q, ha_d;
  logic [DEPTH-1:0][ISSUE_W-1:0][META_W-1:0]  ml_q, ml_d;
  logic [DEPTH-1:0][ISSUE_W-1:0]              ce_q, ce_d;

  // Lanes are applied in ascending order against a running bitmap. A later
  // lane that lands on a position that is already set is dropped. This keeps
  // the lowest-lane value, whether the clash is with older data or with
  // another lane in the same cycle.
  always_comb begin
    fill_d = fill_q;
    hv_d   = hv_q;
    ha_d   = ha_q;
    ml_d   = ml_q;
    ce_d   = ce_q;
    dup    = 1'b0;
    if (clr_en) fill_d[clr_slot] = '0;
    for (int l = 0; l < NUM_PE; l++) begin
      if (we[l]) begin
        if (fill_d[wslot[l]][woff[l]]) begin
          dup = 1'b1;
        end else begin
          fill_d[wslot[l]][woff[l]] = 1'b1;
          hv_d[wslot[l]][woff[l]]   = w_hist_valid[l];
          ha_d[wslot[l]][woff[l]]   = w_hist_addr[l];
          ml_d[wslot[l]][woff[l]]   = w_meta_len[l];
          ce_d[wslot[l]][woff[l]]   = w_can_ext[l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fill_q <= '0;
    else     fill_q <= fill_d;
  end

  // The payload needs no reset: it is only read once every fill bit of the slot is set.
  always_ff @(posedge clk) begin
    hv_q <= hv_d;
    ha_q <= ha_d;
    ml_q <= ml_d;
    ce_q <= ce_d;
  end

  assign rd_full       = &fill_d[rd_slot];
  assign rd_hist_valid = hv_d[rd_slot];
  assign rd_hist_addr  = ha_d[rd_slot];
  assign rd_meta_len   = ml_d[rd_slot];
  assign rd_can_ext    = ce_d[rd_slot];
endmodule

// File: rtl/post_hash_reorder_buffer.sv
// Post-hash reorder buffer. Collects per-PE hash results that arrive out of
// order and releases them as complete, in-order ISSUE_W-wide windows.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   bus        post_hash_reorder_buffer_if.slave:
//                cfg_max_windows   occupancy cap
//                alloc_*           opens a window
//                res_*             per-lane results
//                out_*             retired window, held while not accepted
//                occupancy         windows allocated and not yet retired
//                err_sticky        sticky error flags
// Slot of a window = (head_addr / ISSUE_W) mod DEPTH. The issue side opens
// windows at consecutive bases, so the tail pointer and the address-derived
// slot agree.
module post_hash_reorder_buffer
  import post_hash_reorder_buffer_pkg::*;
#(
  parameter int NUM_PE  = NUM_PE_DEF,
  parameter int ISSUE_W = ISSUE_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int META_W  = META_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  post_hash_reorder_buffer_if.slave bus
);
  localparam int OFF_W = $clog2(ISSUE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int TAG_W = ADDR_W - OFF_W;

  // Extra MSB on both pointers tells full from empty.
  logic [PTR_W-1:0]                 head_ptr, tail_ptr, occ, cap;
  logic [IDX_W-1:0]                 head_idx, tail_idx;
  logic [DEPTH-1:0]                 slot_vld;
  logic [DEPTH-1:0][TAG_W-1:0]      slot_tag;
  logic [DEPTH-1:0][ISSUE_W-1:0][7:0] slot_data;
  logic [DEPTH-1:0]                 slot_delim;

  logic                             alloc_fire, retire, dup;
  logic [TAG_W-1:0]                 alloc_tag;
  logic [NUM_PE-1:0]                lane_we, lane_oor;
  logic [NUM_PE-1:0][IDX_W-1:0]     lane_slot;
  logic [NUM_PE-1:0][OFF_W-1:0]     lane_off;
  logic [ERR_W-1:0]                 err_set, err_q;

  logic                             rd_full;
  logic [ISSUE_W-1:0]               rd_hist_valid, rd_can_ext;
  logic [ISSUE_W-1:0][ADDR_W-1:0]   rd_hist_addr;
  logic [ISSUE_W-1:0][META_W-1:0]   rd_meta_len;

  logic                             out_valid_q, out_delim_q;
  logic [ADDR_W-1:0]                out_head_q;
  logic [ISSUE_W-1:0]               out_hv_q, out_ce_q;
  logic [ISSUE_W-1:0][ADDR_W-1:0]   out_ha_q;
  logic [ISSUE_W-1:0][META_W-1:0]   out_ml_q;
  logic [ISSUE_W-1:0][7:0]          out_data_q;

  // The offset bits of the window base carry no information.
  logic unused_base_bits;
  assign unused_base_bits = ^bus.alloc_head_addr[OFF_W-1:0];

  assign head_idx  = head_ptr[IDX_W-1:0];
  assign tail_idx  = tail_ptr[IDX_W-1:0];
  assign occ       = tail_ptr - head_ptr;
  assign cap       = (bus.cfg_max_windows == '0) ? PTR_W'(1) : bus.cfg_max_windows;
  // Built from registered state and config only. It does not look at
  // out_ready, so a slot freed by a retire is offered again one cycle later.
  assign bus.alloc_ready = ~rst & (occ < cap) & (occ < PTR_W'(DEPTH));
  assign alloc_fire = bus.alloc_valid & bus.alloc_ready;
  assign alloc_tag  = bus.alloc_head_addr[ADDR_W-1:OFF_W];

  // A result is accepted if it hits a live slot with a matching tag, or the
  // slot that is being allocated in this same cycle.
  always_comb begin
    lane_we  = '0;
    lane_oor = '0;
    for (int l = 0; l < NUM_PE; l++) begin
      lane_slot[l] = bus.res_addr[l][OFF_W +: IDX_W];
      lane_off[l]  = bus.res_addr[l][OFF_W-1:0];
      if (bus.res_valid[l]) begin
        if ((slot_vld[lane_slot[l]] && slot_tag[lane_slot[l]] == bus.res_addr[l][ADDR_W-1:OFF_W]) ||
            (alloc_fire && lane_slot[l] == tail_idx && alloc_tag == bus.res_addr[l][ADDR_W-1:OFF_W]))
          lane_we[l] = 1'b1;
        else
          lane_oor[l] = 1'b1;
      end
    end
  end

  rob_slot_bank #(
    .NUM_PE(NUM_PE), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .META_W(META_W)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .clr_en       (alloc_fire),
    .clr_slot     (tail_idx),
    .we           (lane_we),
    .wslot        (lane_slot),
    .woff         (lane_off),
    .w_hist_valid (bus.res_hist_valid),
    .w_hist_addr  (bus.res_hist_addr),
    .w_meta_len   (bus.res_meta_len),
    .w_can_ext    (bus.res_can_ext),
    .rd_slot      (head_idx),
    .rd_full      (rd_full),
    .rd_hist_valid(rd_hist_valid),
    .rd_hist_addr (rd_hist_addr),
    .rd_meta_len  (rd_meta_len),
    .rd_can_ext   (rd_can_ext),
    .dup          (dup)
  );

  // rd_full includes this cycle's writes. A window therefore retires on the
  // same edge that captures its last result.
  assign retire = slot_vld[head_idx] & rd_full & (~out_valid_q | bus.out_ready);

  always_comb begin
    err_set          = '0;
    err_set[ERR_OOR] = |lane_oor;
    err_set[ERR_DUP] = dup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr    <= '0;
      tail_ptr    <= '0;
      slot_vld    <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      out_delim_q <= 1'b0;
      out_head_q  <= '0;
      out_hv_q    <= '0;
      out_ha_q    <= '0;
      out_ml_q    <= '0;
      out_ce_q    <= '0;
      out_data_q  <= '0;
    end else begin
      err_q <= err_q | err_set;
      if (alloc_fire) begin
        slot_vld[tail_idx]   <= 1'b1;
        slot_tag[tail_idx]   <= alloc_tag;
        slot_data[tail_idx]  <= bus.alloc_data;
        slot_delim[tail_idx] <= bus.alloc_delim;
        tail_ptr             <= tail_ptr + PTR_W'(1);
      end
      // The tail slot is always free, so alloc and retire never touch the same slot.
      if (retire) begin
        slot_vld[head_idx] <= 1'b0;
        head_ptr    <= head_ptr + PTR_W'(1);
        out_valid_q <= 1'b1;
        out_head_q  <= {slot_tag[head_idx], {OFF_W{1'b0}}};
        out_data_q  <= slot_data[head_idx];
        out_delim_q <= slot_delim[head_idx];
        out_hv_q    <= rd_hist_valid;
        out_ha_q    <= rd_hist_addr;
        out_ml_q    <= rd_meta_len;
        out_ce_q    <= rd_can_ext;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_head_addr  = out_head_q;
  assign bus.out_hist_valid = out_hv_q;
  assign bus.out_hist_addr  = out_ha_q;
  assign bus.out_meta_len   = out_ml_q;
  assign bus.out_can_ext    = out_ce_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_delim      = out_delim_q;
  assign bus.occupancy      = occ;
  assign bus.err_sticky     = err_q;
endmodule
